// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants and FSM state encoding for the PS/2
//                keyboard receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam int         FRAME_BITS = 11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_fifo
//  Description : First-word-fall-through byte FIFO. A push into a full FIFO
//                is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic        w_do_pop;
    logic        w_do_push;

    // The extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Head reads as zero while empty so data is 0x00 out of reset.
    assign o_data    = o_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];

    // Pointer update on accepted push / pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 keyboard receiver: synchronizes the bus, deframes
//                11-bit frames, validates them, buffers good bytes in a FIFO
//                and counts make codes (break/extension aware).
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] key_count
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic        r_clk_s1, r_clk_s2, r_clk_s3;
    logic        r_dat_s1, r_dat_s2;
    logic        w_fall;

    state_t          r_state,  w_state_nxt;
    logic [3:0]      r_bitcnt, w_bitcnt_nxt;
    logic [TW-1:0]   r_tcnt,   w_tcnt_nxt;
    logic [10:0]     r_shift,  w_shift_nxt;
    logic            r_done,   w_done_nxt;
    logic            w_timeout;

    logic            w_good;
    logic [7:0]      w_byte;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;

    logic            r_overflow;
    logic            r_frame_err;
    logic            r_break;
    logic [7:0]      r_key_count;

    // Two-flop synchronizers plus a third clock flop for edge detection; idle bus is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_s3 & ~r_clk_s2;

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
            r_shift  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state: capture a bit per falling edge, abort on a stalled frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_tcnt_nxt   = r_tcnt;
        w_shift_nxt  = r_shift;
        w_done_nxt   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tcnt_nxt = '0;
                if (w_fall) begin
                    w_shift_nxt    = '0;
                    w_shift_nxt[0] = r_dat_s2;
                    w_bitcnt_nxt   = 4'd1;
                    w_state_nxt    = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_fall) begin
                    w_shift_nxt[r_bitcnt] = r_dat_s2;
                    w_tcnt_nxt            = '0;
                    if (r_bitcnt == LAST_BIT) begin
                        w_bitcnt_nxt = '0;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end
                end else if (r_tcnt == TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_bitcnt_nxt = '0;
                    w_tcnt_nxt   = '0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame check: start low, stop high, odd parity over data plus parity bit.
    assign w_byte = r_shift[8:1];
    assign w_good = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
    assign w_push = r_done & w_good;
    assign w_pop  = rd_en & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    // Error pulse, sticky overflow, and make-code counting with break tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_break     <= 1'b0;
            r_key_count <= '0;
        end else begin
            r_frame_err <= (r_done & ~w_good) | w_timeout;
            if (w_drop) r_overflow <= 1'b1;
            if (w_push) begin
                if (w_byte == BREAK_CODE) begin
                    r_break <= 1'b1;
                end else if (w_byte == EXT_CODE) begin
                    r_break <= r_break;
                end else if (r_break) begin
                    r_break <= 1'b0;
                end else begin
                    r_key_count <= r_key_count + 8'd1;
                end
            end
        end
    end

    ps2_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_byte),
        .o_data  (data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign valid     = ~w_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    assign key_count = r_key_count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_kbd_rx
//  Description : Directed self-checking bench for ps2_kbd_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int C_DEPTH   = 8;
    localparam int C_TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       frame_err;
    logic [7:0] key_count;

    int n_vec  = 0;
    int n_err  = 0;
    int n_ferr = 0;
    int ferr_base;

    ps2_kbd_rx #(
        .FIFO_DEPTH     (C_DEPTH),
        .TIMEOUT_CYCLES (C_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data      (data),
        .valid     (valid),
        .overflow  (overflow),
        .frame_err (frame_err),
        .key_count (key_count)
    );

    always #5 clk = ~clk;

    // Count every clock cycle frame_err is high.
    always @(posedge clk) if (frame_err) n_ferr <= n_ferr + 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drive nbits of a frame; optionally check push latency or pop in the push cycle.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit chk_lat, input bit pop_at_push);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (4) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10 && (chk_lat || pop_at_push)) begin
                repeat (3) @(posedge clk);
                #1 if (pop_at_push) rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
                if (chk_lat) check("latency_valid", 8'(valid), 8'd1);
                repeat (4) @(posedge clk);
                #1;
            end else begin
                repeat (8) @(posedge clk);
                #1;
            end
            ps2_clk = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 8'(valid), 8'd1);
        check({tag, "_data"}, data, exp);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        // Reset state
        check("rst_valid",     8'(valid),     8'd0);
        check("rst_data",      data,          8'h00);
        check("rst_overflow",  8'(overflow),  8'd0);
        check("rst_frame_err", 8'(frame_err), 8'd0);
        check("rst_key_count", key_count,     8'd0);

        // Single good frame 0x1C with latency check, then pop
        ferr_base = n_ferr;
        send_frame(8'h1C, 1'b0, 11, 1'b1, 1'b0);
        check("good_valid", 8'(valid), 8'd1);
        check("good_data",  data,      8'h1C);
        check("good_keys",  key_count, 8'd1);
        check("good_noerr", 8'(n_ferr - ferr_base), 8'd0);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        check("good_popped", 8'(valid), 8'd0);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        check("empty_pop_ignored", 8'(valid), 8'd0);

        // Break/extension sequence
        do_reset();
        send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1'b0, 1'b0);
        check("seq_keys", key_count, 8'd2);
        pop_check("seq0", 8'h1C);
        pop_check("seq1", 8'hF0);
        pop_check("seq2", 8'h1C);
        pop_check("seq3", 8'hE0);
        pop_check("seq4", 8'h75);
        check("seq_empty", 8'(valid), 8'd0);

        // Bad parity
        do_reset();
        ferr_base = n_ferr;
        send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0);
        check("par_err_cycles", 8'(n_ferr - ferr_base), 8'd1);
        check("par_valid",      8'(valid), 8'd0);
        check("par_keys",       key_count, 8'd0);

        // Overflow: nine frames into depth 8
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 11, 1'b0, 1'b0);
        check("ovf_flag", 8'(overflow), 8'd1);
        check("ovf_keys", key_count, 8'd9);
        for (int i = 1; i <= 8; i++) pop_check("ovf_pop", 8'(i));
        check("ovf_empty", 8'(valid), 8'd0);
        check("ovf_sticky", 8'(overflow), 8'd1);

        // Full FIFO with pop in the push cycle: byte accepted, no overflow
        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h09, 1'b0, 11, 1'b0, 1'b1);
        check("fullpop_ovf", 8'(overflow), 8'd0);
        for (int i = 2; i <= 9; i++) pop_check("fullpop", 8'(i));
        check("fullpop_empty", 8'(valid), 8'd0);

        // Timeout after five bits, then a good frame
        do_reset();
        ferr_base = n_ferr;
        send_frame(8'h55, 1'b0, 5, 1'b0, 1'b0);
        repeat (C_TIMEOUT + 10) @(posedge clk);
        #1;
        check("tmo_err_cycles", 8'(n_ferr - ferr_base), 8'd1);
        check("tmo_valid",      8'(valid), 8'd0);
        send_frame(8'h2A, 1'b0, 11, 1'b0, 1'b0);
        check("tmo_next_keys", key_count, 8'd1);
        pop_check("tmo_next", 8'h2A);
        check("tmo_next_empty", 8'(valid), 8'd0);

        // Reset mid-frame, then a good frame
        do_reset();
        send_frame(8'hA5, 1'b0, 7, 1'b0, 1'b0);
        do_reset();
        send_frame(8'h33, 1'b0, 11, 1'b0, 1'b0);
        check("midrst_keys", key_count, 8'd1);
        check("midrst_ovf",  8'(overflow), 8'd0);
        pop_check("midrst", 8'h33);
        check("midrst_empty", 8'(valid), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of scancode bytes buffered; power of two, 2 to 64.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, number of idle clk cycles mid-frame before the frame is aborted.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 rd_en  input  1  pop request for the FIFO head.
REQ-008 data  output  8  FIFO head byte, first-word-fall-through.
REQ-009 valid  output  1  FIFO non-empty.
REQ-010 overflow  output  1  sticky flag: a good frame was dropped because the FIFO was full.
REQ-011 frame_err  output  1  one-cycle pulse: start, stop or parity check failed, or the frame timed out.
REQ-012 key_count  output  8  count of make codes received.

Function
REQ-013 ps2_clk and ps2_data pass through 2-flop synchronizers; a third ps2_clk flop provides falling-edge detect (previous 1, current 0).
REQ-014 State machine IDLE/RECV:
- IDLE -> RECV on the first falling edge, capturing bit 0.
- RECV -> IDLE after the 11th bit, or on timeout.
REQ-015 Bits are sampled from synchronized ps2_data on each detected falling edge, in this order: start, d0..d7 (LSB first), odd parity, stop; a 4-bit counter runs 0..10.
REQ-016 A frame is good when start=0, stop=1, and d0..d7 plus the parity bit contain an odd number of ones.
REQ-017 Good frame: push the byte in the cycle after the 11th bit is captured.
REQ-018 Bad frame: pulse frame_err for that cycle, push nothing, leave key_count unchanged.
REQ-019 Timeout: in RECV with no falling edge for TIMEOUT_CYCLES consecutive cycles, pulse frame_err, clear the bit counter, return to IDLE, discard partial data.
REQ-020 valid is high at most 4 clk cycles after the stop-bit falling edge at the pins.
REQ-021 FIFO:
- Circular buffer with pointers of log2(FIFO_DEPTH)+1 bits.
- Empty when pointers are equal; full when indices match and the MSBs differ.
REQ-022 Pop occurs when rd_en and valid; rd_en while empty is ignored.
REQ-023 Push while full without a pop in the same cycle: drop the byte and set overflow.
REQ-024 Push while full with a pop in the same cycle: accept the byte; no overflow.
REQ-025 overflow clears only on reset.
REQ-026 Break and extension code handling:
- Good byte 0xF0 sets break_pending.
- Good byte 0xE0 changes no state.
- Any other good byte with break_pending=1 clears break_pending and is not counted.
- Any other good byte with break_pending=0 increments key_count.
REQ-027 key_count wraps from 255 to 0.
REQ-028 Every good byte is pushed, including 0xF0 and 0xE0, whether counted or not.
REQ-029 A good frame is counted even when its push is dropped for overflow.

Reset
REQ-030 On reset:
- State IDLE, bit counter 0, timeout counter 0.
- FIFO pointers 0; valid=0, data=0x00.
- overflow=0, frame_err=0, key_count=0, break_pending=0.
- Synchronizer flops set to 1 (idle bus).
REQ-031 Reset mid-frame discards the partial frame; reception restarts at the next start-bit falling edge after reset deasserts.

Structure
REQ-032 Shared package ps2_pkg holds BREAK_CODE=0xF0, EXT_CODE=0xE0, FRAME_BITS=11 and the IDLE/RECV state encoding.
REQ-033 The FIFO is a sub-module named ps2_fifo (FIFO_DEPTH parameter, push/pop/full/empty); the frame FSM, synchronizers and counters stay in ps2_kbd_rx.

Verification
REQ-034 Good frame 0x1C (parity 0) -> valid high with data=0x1C, key_count=1, frame_err never asserted; rd_en -> valid=0.
REQ-035 Frames 0x1C, 0xF0, 0x1C, E0, 0x75 -> five FIFO entries in order; key_count=2 (first 0x1C and 0x75).
REQ-036 Frame 0x1C sent with parity 1 -> one-cycle frame_err, valid stays 0, key_count=0.
REQ-037 Nine good frames 0x01..0x09 with no reads (depth 8) -> overflow=1; pops return 0x01..0x08, then valid=0; key_count=9.
REQ-038 Five bits sent, then ps2_clk held high for TIMEOUT_CYCLES+10 cycles -> single frame_err pulse; a following good 0x2A frame is received correctly.
REQ-039 reset asserted after bit 6 of a frame, then a good 0x33 frame -> only 0x33 in the FIFO, key_count=1, overflow=0.
